// File: rtl/booth_mult_arbiter_if.sv
// Request/response bundle between two multiply requesters, the shared Booth
// multiplier, and the consumer of its tagged products.
interface booth_mult_arbiter_if #(
    parameter int WIDTH = 4
);
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [WIDTH-1:0]   req0_mcand;
    logic [WIDTH-1:0]   req0_mplier;
    logic [WIDTH-1:0]   req1_mcand;
    logic [WIDTH-1:0]   req1_mplier;
    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_id;
    logic [2*WIDTH-1:0] rsp_product;
    logic               busy;

    modport master (
        output req_valid, req0_mcand, req0_mplier, req1_mcand, req1_mplier, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_product, busy
    );

    modport slave (
        input  req_valid, req0_mcand, req0_mplier, req1_mcand, req1_mplier, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_product, busy
    );
endinterface

// File: rtl/booth_mult_arbiter.sv
// Two-requester arbiter in front of one sequential radix-2 Booth multiplier.
// Define BOOTH_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties).
module booth_mult_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    booth_mult_arbiter_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH:0]   m_q, m_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             q1_q, q1_d;
    logic [CW-1:0]    count_q, count_d;
    logic             id_q, id_d;
`ifndef BOOTH_ARB_FIXED_PRIO_EN
    logic             last_q, last_d;
`endif

    logic             winner;
    logic [1:0]       grant;
    logic             handshake;
    logic [WIDTH-1:0] sel_mcand;
    logic [WIDTH-1:0] sel_mplier;
    logic [WIDTH:0]   booth_sum;

    always_comb begin
        winner = 1'b0;
`ifdef BOOTH_ARB_FIXED_PRIO_EN
        winner = ~bus.req_valid[0];
`else
        if (bus.req_valid == 2'b11) begin
            winner = ~last_q;
        end else begin
            winner = bus.req_valid[1];
        end
`endif
    end

    // Grant is only offered while idle and out of reset; it is purely combinational.
    always_comb begin
        grant = 2'b00;
        if (state_q == ST_IDLE && !rst && bus.req_valid != 2'b00) begin
            grant = winner ? 2'b10 : 2'b01;
        end
    end

    assign handshake  = |(bus.req_valid & grant);
    assign sel_mcand  = winner ? bus.req1_mcand  : bus.req0_mcand;
    assign sel_mplier = winner ? bus.req1_mplier : bus.req0_mplier;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        m_d       = m_q;
        q_d       = q_q;
        q1_d      = q1_q;
        count_d   = count_q;
        id_d      = id_q;
`ifndef BOOTH_ARB_FIXED_PRIO_EN
        last_d    = last_q;
`endif
        booth_sum = a_q;

        case ({q_q[0], q1_q})
            2'b01:   booth_sum = a_q + m_q;
            2'b10:   booth_sum = a_q - m_q;
            default: booth_sum = a_q;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    m_d     = {sel_mcand[WIDTH-1], sel_mcand};
                    a_d     = '0;
                    q_d     = sel_mplier;
                    q1_d    = 1'b0;
                    count_d = CW'(WIDTH);
                    id_d    = winner;
`ifndef BOOTH_ARB_FIXED_PRIO_EN
                    last_d  = winner;
`endif
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Arithmetic right shift of {A,Q,Q_1}; A carries one guard bit.
                a_d     = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                q_d     = {booth_sum[0], q_q[WIDTH-1:1]};
                q1_d    = q_q[0];
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            m_q     <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            count_q <= '0;
            id_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            m_q     <= m_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            count_q <= count_d;
            id_q    <= id_d;
        end
    end

`ifndef BOOTH_ARB_FIXED_PRIO_EN
    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign bus.req_ready   = grant;
    assign bus.rsp_valid   = (state_q == ST_DONE);
    assign bus.rsp_id      = id_q;
    assign bus.rsp_product = {a_q[WIDTH-1:0], q_q};
    assign bus.busy        = (state_q != ST_IDLE);
endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Randomized and directed checks of booth_mult_arbiter against a
// cycle-level behavioural model (plain multiplication plus a countdown).
module tb_booth_mult_arbiter;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    bit   checkOn = 1'b0;

    booth_mult_arbiter_if #(.WIDTH(W)) bus ();

    booth_mult_arbiter #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model: an operation occupies the unit for W stepping clocks, then waits in DONE.
    int             mBusyLeft = 0;
    bit             mDone = 1'b0;
    bit             mLast = 1'b1;
    logic           mId = 1'b0;
    logic [2*W-1:0] mProd = '0;

    function automatic logic pickWinner(input logic [1:0] v, input logic last);
`ifdef BOOTH_ARB_FIXED_PRIO_EN
        return (v[0] ? 1'b0 : 1'b1);
`else
        if (v == 2'b11) return ~last;
        return v[1];
`endif
    endfunction

    function automatic logic [2*W-1:0] refProduct(input logic [W-1:0] a, input logic [W-1:0] b);
        int sa;
        int sb;
        int p;
        sa = int'($signed(a));
        sb = int'($signed(b));
        p  = sa * sb;
        return p[2*W-1:0];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mBusyLeft = 0;
            mDone     = 1'b0;
            mLast     = 1'b1;
        end else if (mBusyLeft == 0 && !mDone && bus.req_valid != 2'b00) begin
            mId       = pickWinner(bus.req_valid, mLast);
            mLast     = mId;
            mProd     = mId ? refProduct(bus.req1_mcand, bus.req1_mplier)
                            : refProduct(bus.req0_mcand, bus.req0_mplier);
            mBusyLeft = W;
        end else if (mBusyLeft > 0) begin
            mBusyLeft = mBusyLeft - 1;
            if (mBusyLeft == 0) mDone = 1'b1;
        end else if (mDone && bus.rsp_ready) begin
            mDone = 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeoutFail(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s actual=timeout expected=event at %0t", name, $time);
    endtask

    always @(negedge clk) begin
        if (checkOn) begin
            logic       idle;
            logic [1:0] expReady;
            idle     = (mBusyLeft == 0) && !mDone;
            expReady = 2'b00;
            if (!rst && idle && bus.req_valid != 2'b00)
                expReady = pickWinner(bus.req_valid, mLast) ? 2'b10 : 2'b01;
            checkOutput("req_ready", 32'(bus.req_ready), 32'(expReady));
            checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'(mDone));
            checkOutput("busy", 32'(bus.busy), 32'(!idle));
            if (rst) begin
                checkOutput("rst_product", 32'(bus.rsp_product), 32'h0);
                checkOutput("rst_id", 32'(bus.rsp_id), 32'h0);
            end else if (mDone) begin
                checkOutput("rsp_product", 32'(bus.rsp_product), 32'(mProd));
                checkOutput("rsp_id", 32'(bus.rsp_id), 32'(mId));
            end
        end
    end

    task automatic applyStimulus(input logic [1:0] v, input logic [W-1:0] m0, input logic [W-1:0] p0,
                                 input logic [W-1:0] m1, input logic [W-1:0] p1, input logic rr);
        bus.req_valid   = v;
        bus.req0_mcand  = m0;
        bus.req0_mplier = p0;
        bus.req1_mcand  = m1;
        bus.req1_mplier = p1;
        bus.rsp_ready   = rr;
    endtask

    // Issue one request, scramble operands after handshake, return the response.
    task automatic doOp(input int sel, input logic [W-1:0] mc, input logic [W-1:0] mp,
                        output logic id, output logic [2*W-1:0] prod, output int lat);
        bit found;
        applyStimulus(sel == 1 ? 2'b10 : 2'b01, mc, mp, mc, mp, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.req_ready != 2'b00) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) timeoutFail("handshake_wait");
        @(posedge clk);
        #1;
        applyStimulus(2'b00, W'($urandom), W'($urandom), W'($urandom), W'($urandom), 1'b1);
        lat = 0;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            lat++;
            if (bus.rsp_valid) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) timeoutFail("rsp_wait");
        id   = bus.rsp_id;
        prod = bus.rsp_product;
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic           id;
        logic [2*W-1:0] prod;
        int             lat;
        logic [1:0]     expIds [4];
        logic [1:0]     gotIds [4];
        bit             found;

        applyStimulus(2'b00, '0, '0, '0, '0, 1'b1);
        @(negedge clk);
        checkOn = 1'b1;
        checkOutput("reset_ready", 32'(bus.req_ready), 32'h0);
        checkOutput("reset_valid", 32'(bus.rsp_valid), 32'h0);
        checkOutput("reset_id", 32'(bus.rsp_id), 32'h0);
        checkOutput("reset_product", 32'(bus.rsp_product), 32'h0);
        checkOutput("reset_busy", 32'(bus.busy), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        doOp(0, 4'h3, 4'hE, id, prod, lat);
        checkOutput("op_3x-2_prod", 32'(prod), 32'hFA);
        checkOutput("op_3x-2_id", 32'(id), 32'h0);
        checkOutput("op_3x-2_latency", 32'(lat), 32'd5);

        doOp(1, 4'h8, 4'h8, id, prod, lat);
        checkOutput("op_-8x-8_prod", 32'(prod), 32'h40);
        checkOutput("op_-8x-8_id", 32'(id), 32'h1);

        doOp(1, 4'h8, 4'h7, id, prod, lat);
        checkOutput("op_-8x7_prod", 32'(prod), 32'hC8);
        checkOutput("op_-8x7_id", 32'(id), 32'h1);

        // Both requesters held valid from reset.
        pulseReset();
`ifdef BOOTH_ARB_FIXED_PRIO_EN
        expIds = '{2'd0, 2'd0, 2'd0, 2'd0};
`else
        expIds = '{2'd0, 2'd1, 2'd0, 2'd1};
`endif
        applyStimulus(2'b11, 4'h2, 4'h3, 4'hF, 4'h5, 1'b1);
        for (int k = 0; k < 4; k++) begin
            found = 1'b0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (bus.rsp_valid) begin
                    found = 1'b1;
                    break;
                end
            end
            if (!found) timeoutFail("rr_rsp_wait");
            gotIds[k] = {1'b0, bus.rsp_id};
            checkOutput($sformatf("rr_prod_%0d", k), 32'(bus.rsp_product),
                        (expIds[k] == 2'd0) ? 32'h06 : 32'hFB);
            @(posedge clk);
            #1;
            if (k == 3) bus.req_valid = 2'b00;
        end
        for (int k = 0; k < 4; k++)
            checkOutput($sformatf("rr_grant_%0d", k), 32'(gotIds[k]), 32'(expIds[k]));

        // Backpressure: response must hold while rsp_ready stays low.
        applyStimulus(2'b10, 4'h0, 4'h0, 4'h8, 4'h7, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) timeoutFail("bp_rsp_wait");
        bus.req_valid = 2'b11;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("bp_valid", 32'(bus.rsp_valid), 32'h1);
            checkOutput("bp_prod", 32'(bus.rsp_product), 32'hC8);
            checkOutput("bp_id", 32'(bus.rsp_id), 32'h1);
            checkOutput("bp_ready", 32'(bus.req_ready), 32'h0);
        end
        @(posedge clk);
        #1;
        applyStimulus(2'b00, '0, '0, '0, '0, 1'b1);
        @(posedge clk);
        #1;

        // Reset in the second BUSY clock aborts the operation.
        applyStimulus(2'b01, 4'h3, 4'hE, 4'h0, 4'h0, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.req_ready != 2'b00) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) timeoutFail("abort_handshake_wait");
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_busy", 32'(bus.busy), 32'h0);
        checkOutput("abort_product", 32'(bus.rsp_product), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("abort_no_rsp", 32'(bus.rsp_valid), 32'h0);
        end
        doOp(0, 4'h3, 4'hE, id, prod, lat);
        checkOutput("after_abort_prod", 32'(prod), 32'hFA);
        checkOutput("after_abort_id", 32'(id), 32'h0);

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            applyStimulus(2'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom),
                          ($urandom_range(0, 3) != 0));
        end
        @(posedge clk);
        #1;
        applyStimulus(2'b00, '0, '0, '0, '0, 1'b1);
        repeat (12) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
